serializer_8b10b_multi: RTL

SERIALIZER_8B10B_MULTI -- requirements
Module: serializer_8b10b_multi

---
 rtl/serializer_8b10b_multi.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/serializer_8b10b_multi.sv
// Multi-byte 8b/10b encoder and serializer: encodes NUM_BYTES bytes per word with chained
// running disparity and shifts them out one bit per clock, filling idle slots with fill characters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE_FILL | shifting an idle fill frame (or the reset-exit slot)
// SHIFT     | shifting a frame built from an accepted word
module serializer_8b10b_multi #(
    parameter int NUM_BYTES  = 2,
    parameter bit A_FIRST    = 1'b1,
    parameter bit IDLE_COMMA = 1'b1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [8*NUM_BYTES-1:0]  i_Data,
    input  logic [NUM_BYTES-1:0]    i_K,
    input  logic                    i_Valid,
    output logic                    o_Ready,
    output logic                    o_Ser_Data,
    output logic                    o_Ser_Data_Flag,
    output logic [10*NUM_BYTES-1:0] o_10B,
    output logic                    o_RD,
    output logic                    o_Code_Err
);

    localparam int            NBITS     = 10 * NUM_BYTES;
    localparam int            CW        = $clog2(NBITS);
    localparam logic [CW-1:0] LAST      = CW'(NBITS - 1);
    localparam logic [7:0]    FILL_BYTE = IDLE_COMMA ? 8'hBC : 8'hB5;
    localparam logic          FILL_K    = IDLE_COMMA;

    typedef enum logic {
        IDLE_FILL = 1'b0,
        SHIFT     = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] tenb_q, tenb_d;
    logic             rd_q, rd_d;
    logic             err_q, err_d;
    logic             start_q, start_d;

    logic [NBITS-1:0] data_code, idle_code, load_code, load_ser;
    logic             data_rd, idle_rd, data_bad;
    logic             boundary, accept;

    function automatic logic k_legal(input logic [7:0] d);
        return (d[4:0] == 5'd28) ||
               ((d[7:5] == 3'd7) && ((d[4:0] == 5'd23) || (d[4:0] == 5'd27) ||
                                     (d[4:0] == 5'd29) || (d[4:0] == 5'd30)));
    endfunction

    // abcdei as sent at RD-; the RD+ form is the complement where the code is not neutral
    function automatic logic [5:0] enc_6b(input logic [4:0] x, input logic k);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        if (k && (x == 5'd28)) c = 6'b001111;
        return c;
    endfunction

    // returns {rd_out, a,b,c,d,e,i,f,g,h,j}
    function automatic logic [10:0] encode_byte(input logic [7:0] d, input logic k,
                                                input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd6;
        logic       alt7;
        x  = d[4:0];
        y  = d[7:5];
        c6 = enc_6b(x, k);
        if (rd_in && (($countones(c6) != 3) || (x == 5'd7))) c6 = ~c6;
        rd6  = rd_in ^ ($countones(c6) != 3);
        alt7 = k || (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)))
                 || ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
        case (y)
            3'd0:    c4 = 4'b1011;
            3'd1:    c4 = 4'b1001;
            3'd2:    c4 = 4'b0101;
            3'd3:    c4 = 4'b1100;
            3'd4:    c4 = 4'b1101;
            3'd5:    c4 = 4'b1010;
            3'd6:    c4 = 4'b0110;
            default: c4 = alt7 ? 4'b0111 : 4'b1110;
        endcase
        // control characters invert the neutral fghj patterns when following an RD- sub-block
        if (rd6 && (($countones(c4) != 2) || (y == 3'd3))) c4 = ~c4;
        else if (k && !rd6 && ($countones(c4) == 2) && (y != 3'd3)) c4 = ~c4;
        return {rd6 ^ ($countones(c4) != 2), c6, c4};
    endfunction

    always_comb begin
        logic       rd_a;
        logic       rd_b;
        logic [7:0] byte_v;
        logic       k_v;
        logic [10:0] r;
        data_code = '0;
        idle_code = '0;
        data_bad  = 1'b0;
        rd_a      = rd_q;
        rd_b      = rd_q;
        for (int k = 0; k < NUM_BYTES; k++) begin
            byte_v = i_Data[8*k +: 8];
            k_v    = i_K[k];
            if (k_v && !k_legal(byte_v)) begin
                byte_v   = 8'hBC;
                data_bad = 1'b1;
            end
            r = encode_byte(byte_v, k_v, rd_a);
            data_code[10*k +: 10] = r[9:0];
            rd_a = r[10];
            r = encode_byte(FILL_BYTE, FILL_K, rd_b);
            idle_code[10*k +: 10] = r[9:0];
            rd_b = r[10];
        end
        data_rd = rd_a;
        idle_rd = rd_b;
    end

    assign boundary = start_q || (cnt_q == LAST);
    assign o_Ready  = boundary && !i_Rst;
    assign accept   = i_Valid && o_Ready;

    // shift order: position 0 of load_ser leaves first
    always_comb begin
        load_code = accept ? data_code : idle_code;
        load_ser  = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            for (int i = 0; i < 10; i++) begin
                load_ser[10*k + i] = A_FIRST ? load_code[10*k + 9 - i] : load_code[10*k + i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        shift_d = {1'b0, shift_q[NBITS-1:1]};
        tenb_d  = tenb_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        start_d = start_q;
        if (boundary) begin
            start_d = 1'b0;
            cnt_d   = '0;
            shift_d = load_ser;
            tenb_d  = load_code;
            if (accept) begin
                state_d = SHIFT;
                rd_d    = data_rd;
                err_d   = data_bad;
            end else begin
                state_d = IDLE_FILL;
                rd_d    = idle_rd;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE_FILL;
            cnt_q   <= '0;
            shift_q <= '0;
            tenb_q  <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tenb_q  <= tenb_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    assign o_Ser_Data      = shift_q[0];
    assign o_Ser_Data_Flag = (state_q == SHIFT);
    assign o_10B           = tenb_q;
    assign o_RD            = rd_q;
    assign o_Code_Err      = err_q;

endmodule
